// File: rtl/async_fifo_pkg.sv
// ---------------------------------------------------------------------------
// async_fifo_pkg
// Shared constants for the async FIFO read-side blocks.
//   DATA_WIDTH_DEF : default FIFO word / stream data width
//   RD_GAP_DEF     : default idle cycles forced after each FIFO read enable
//   CNT_WIDTH_DEF  : default width of the delivered-word counter
//   gap_width()    : register width needed to hold a gap count of 0..gap
// ---------------------------------------------------------------------------
package async_fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned RD_GAP_DEF     = 1;
    localparam int unsigned CNT_WIDTH_DEF  = 16;

    // A zero gap still needs a 1-bit register so the counter logic stays uniform.
    function automatic int unsigned gap_width(input int unsigned gap);
        return (gap > 0) ? $clog2(gap + 1) : 1;
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// ---------------------------------------------------------------------------
// stream_skid_buf
// Two-entry register FIFO used as the output buffer of a valid/ready stream.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_push       : write i_data into the tail (dropped only if full without pop)
//   i_data       : word to push
//   i_pop        : remove the head word (ignored when empty)
//   o_count      : number of buffered words, 0..2
//   o_valid      : buffer holds at least one word
//   o_data       : head word, driven from registers only
// ---------------------------------------------------------------------------
module stream_skid_buf
    import async_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [1:0]            o_count,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_head;
    logic [1:0]            r_count;

    logic w_pop_ok;
    logic w_push_ok;
    logic w_tail;

    assign w_pop_ok  = i_pop && (r_count != 2'd0);
    assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);
    // Tail is head+count mod 2; with count==2 and a same-cycle pop this is the
    // slot being freed, so order stays strictly FIFO.
    assign w_tail    = r_head ^ r_count[0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[w_tail] <= i_data;
            end
            if (w_pop_ok) begin
                r_head <= ~r_head;
            end
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_head];

endmodule

// File: rtl/async_fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// async_fifo_rd_stream
// Read-side consumer of the async FIFO (rclk domain). Pulls words with ren,
// captures rdata one cycle later and presents them on a valid/ready stream.
// Ports:
//   rclk, rrst : read clock, asynchronous active-high reset (shared with FIFO)
//   r_empty    : FIFO empty flag (registered in the FIFO)
//   ren        : FIFO read enable (registered)
//   rdata      : FIFO read data, valid the cycle after ren
//   m_valid    : stream valid
//   m_data     : stream data (buffer head, registered)
//   m_ready    : stream accept
//   rd_cnt     : words delivered on the stream, wraps modulo 2^CNT_WIDTH
// ---------------------------------------------------------------------------
module async_fifo_rd_stream
    import async_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned RD_GAP     = RD_GAP_DEF,
    parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  r_empty,
    output logic                  ren,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_cnt
);

    localparam int unsigned GAP_W = gap_width(RD_GAP);

    logic                 r_ren;
    logic                 r_inflight;
    logic [GAP_W-1:0]     r_gap;
    logic [CNT_WIDTH-1:0] r_rd_cnt;

    logic [1:0]           w_buf_count;
    logic                 w_buf_valid;
    logic [DATA_WIDTH-1:0] w_buf_data;
    logic                 w_pop;
    logic [2:0]           w_slots_used;
    logic                 w_issue;

    assign w_pop = w_buf_valid && m_ready;

    // Slots already spoken for: buffered words, the ren on the bus now and the
    // word landing this cycle, minus a word leaving on the stream this cycle.
    // Counting the live ren keeps the credit safe even with RD_GAP=0.
    always_comb begin
        w_slots_used = 3'(w_buf_count) + 3'(r_ren) + 3'(r_inflight) - 3'(w_pop);
        w_issue      = !r_empty && (r_gap == '0) && (w_slots_used < 3'd2);
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_ren      <= 1'b0;
            r_inflight <= 1'b0;
            r_gap      <= '0;
            r_rd_cnt   <= '0;
        end else begin
            r_ren      <= w_issue;
            r_inflight <= r_ren;
            if (w_issue) begin
                r_gap <= GAP_W'(RD_GAP);
            end else if (r_gap != '0) begin
                r_gap <= r_gap - GAP_W'(1);
            end
            if (w_pop) begin
                r_rd_cnt <= r_rd_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Capture needs no space check: the issue credit reserved the slot.
    stream_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .i_clk  (rclk),
        .i_rst  (rrst),
        .i_push (r_inflight),
        .i_data (rdata),
        .i_pop  (w_pop),
        .o_count(w_buf_count),
        .o_valid(w_buf_valid),
        .o_data (w_buf_data)
    );

    assign ren     = r_ren;
    assign m_valid = w_buf_valid;
    assign m_data  = w_buf_data;
    assign rd_cnt  = r_rd_cnt;

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_async_fifo_rd_stream
// Bench for async_fifo_rd_stream with a behavioural FIFO read side and a
// scoreboard of written words. The counter width is narrowed to 4 bits so
// wrap-around is reachable.
// ---------------------------------------------------------------------------
module tb_async_fifo_rd_stream;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;

    logic          rclk = 1'b0;
    logic          rrst = 1'b1;
    logic          r_empty;
    logic          ren;
    logic [DW-1:0] rdata;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic [CW-1:0] rd_cnt;

    async_fifo_rd_stream #(
        .DATA_WIDTH(DW),
        .RD_GAP    (1),
        .CNT_WIDTH (CW)
    ) dut (
        .rclk   (rclk),
        .rrst   (rrst),
        .r_empty(r_empty),
        .ren    (ren),
        .rdata  (rdata),
        .m_valid(m_valid),
        .m_data (m_data),
        .m_ready(m_ready),
        .rd_cnt (rd_cnt)
    );

    always #5 rclk = ~rclk;

    // FIFO read side: rdata one cycle after ren (garbage when popped empty),
    // empty flag registered from the stored word count.
    logic [DW-1:0] fq[$];
    always @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            fq.delete();
            rdata   <= '0;
            r_empty <= 1'b1;
        end else begin
            if (ren) begin
                if (fq.size() != 0) rdata <= fq.pop_front();
                else                rdata <= DW'($urandom);
            end
            r_empty <= (fq.size() == 0);
        end
    end

    // Scoreboard and counters
    logic [DW-1:0] sb[$];
    int unsigned   beats;
    int unsigned   n_pass;
    int unsigned   n_total;
    logic          prev_valid;
    logic [DW-1:0] prev_data;
    logic          prev_ren;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic write_word(input logic [DW-1:0] w);
        fq.push_back(w);
        sb.push_back(w);
    endtask

    // Advance to the next falling edge and check stream rules against the
    // scoreboard. m_ready is only changed right after a tick, so its value
    // now is the one the DUT saw at the preceding rising edge.
    task automatic tick();
        @(negedge rclk);
        if (prev_valid && m_ready) begin
            chk("beat_expected", (sb.size() != 0) ? 1 : 0, 1);
            if (sb.size() != 0) chk("beat_data", prev_data, sb.pop_front());
            beats++;
        end
        chk("rd_cnt_track", rd_cnt, beats % 16);
        if (prev_valid && !m_ready) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, prev_data);
        end
        chk("ren_while_empty", ren & r_empty, 0);
        chk("ren_back_to_back", prev_ren & ren, 0);
        prev_valid = m_valid;
        prev_data  = m_data;
        prev_ren   = ren;
    endtask

    task automatic clear_model();
        sb.delete();
        beats      = 0;
        prev_valid = 1'b0;
        prev_data  = '0;
        prev_ren   = 1'b0;
    endtask

    task automatic do_reset();
        rrst    = 1'b1;
        m_ready = 1'b0;
        clear_model();
        repeat (2) tick();
        rrst = 1'b0;
    endtask

    task automatic drain(input string nm, input bit toggle);
        for (int i = 0; i < 300 && sb.size() != 0; i++) begin
            m_ready = toggle ? ~m_ready : 1'b1;
            tick();
        end
        m_ready = 1'b1;
        repeat (4) tick();
        chk(nm, sb.size(), 0);
    endtask

    typedef struct {
        logic          ready;
        logic          exp_ren;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        int unsigned   exp_cnt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int unsigned pulses;
        int unsigned seen;
        int unsigned written;

        n_pass  = 0;
        n_total = 0;
        clear_model();

        // Three preloaded words, m_ready high: cycles 1..10 after preload.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h11, 0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 8'h22, 1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 2};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 8'h33, 2};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 8'h00, 3};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 8'h00, 3};

        // 1: reset state and idle with an empty FIFO
        do_reset();
        chk("rst_m_data", m_data, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_ren", ren, 0);
            chk("idle_valid", m_valid, 0);
            chk("idle_cnt", rd_cnt, 0);
        end

        // 2: table-driven cycle-exact stream of three words
        do_reset();
        m_ready = 1'b1;
        write_word(8'h11);
        write_word(8'h22);
        write_word(8'h33);
        for (int i = 0; i < 10; i++) begin
            m_ready = tbl[i].ready;
            tick();
            chk($sformatf("vec%0d_ren", i), ren, tbl[i].exp_ren);
            chk($sformatf("vec%0d_valid", i), m_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) chk($sformatf("vec%0d_data", i), m_data, tbl[i].exp_data);
            chk($sformatf("vec%0d_cnt", i), rd_cnt, tbl[i].exp_cnt);
        end

        // 3: backpressure holds at two buffered words
        do_reset();
        for (int i = 0; i < 4; i++) write_word(8'hC0 + 8'(i));
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ren) pulses++;
        end
        chk("bp_ren_pulses", pulses, 2);
        chk("bp_valid", m_valid, 1);
        chk("bp_data", m_data, 8'hC0);
        drain("bp_drain", 1'b0);
        chk("bp_beats", beats, 4);

        // 4: m_ready toggling every cycle over eight words
        do_reset();
        for (int i = 0; i < 8; i++) write_word(8'(i));
        drain("toggle_drain", 1'b1);
        chk("toggle_beats", beats, 8);

        // 5: reset while a word is in flight
        do_reset();
        m_ready = 1'b1;
        write_word(8'h5A);
        write_word(8'h5B);
        write_word(8'h5C);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            tick();
            if (ren) seen = 1;
        end
        chk("mid_ren_seen", seen, 1);
        tick();
        rrst = 1'b1;
        clear_model();
        #1;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_cnt", rd_cnt, 0);
        tick();
        chk("mid_rst_valid_next", m_valid, 0);
        chk("mid_rst_cnt_next", rd_cnt, 0);
        rrst = 1'b0;
        write_word(8'hA5);
        drain("mid_drain", 1'b0);
        repeat (10) tick();
        chk("mid_beats", beats, 1);

        // 6: counter wrap with a 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) write_word(8'h40 + 8'(i));
        drain("wrap_drain", 1'b0);
        chk("wrap_cnt", rd_cnt, 1);

        // Random traffic and backpressure
        do_reset();
        written = 0;
        for (int i = 0; i < 400; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if (fq.size() < 6 && $urandom_range(0, 2) == 0) begin
                write_word(DW'($urandom));
                written++;
            end
            tick();
        end
        drain("rand_drain", 1'b0);
        chk("rand_beats", beats, written);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
